// File: rtl/serpent_pkg.sv
// Serpent shared constants and types for the subkey store slice.
// Exports subkey count/width/index width and the store FSM state type.
package serpent_pkg;

  localparam int SERPENT_NUM_SUBKEYS = 33;
  localparam int SERPENT_KEY_W       = 128;
  localparam int SERPENT_ADDR_W      = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ss_state_t;

endpackage

// File: rtl/subkey_ram.sv
// NUM_KEYS x KEY_W subkey storage: 1 sync write, 1 sync read (registered dout).
// Ports: i_wr_en/i_wr_addr/i_wr_data write, i_rd_en/i_rd_addr read, o_rd_data.
import serpent_pkg::*;

module subkey_ram #(
  parameter int NUM_KEYS = SERPENT_NUM_SUBKEYS,
  parameter int KEY_W    = SERPENT_KEY_W,
  parameter int ADDR_W   = SERPENT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [KEY_W-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [KEY_W-1:0]  o_rd_data
);

  logic [KEY_W-1:0] mem [NUM_KEYS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // dout only moves on a read, so it doubles as the
  // held output register while the consumer stalls
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/serpent_subkey_store.sv
// Serpent subkey store: buffers K0..K32, streams them over valid/ready.
// Ports: i_wr_* load, i_load_done/o_keys_ready, i_start/o_rk_* stream,
// o_busy/o_done/o_err status, i_clear. Option SUBKEY_STORE_REVERSE_EN
// adds i_decrypt (sampled at start) for K32..K0 order.
import serpent_pkg::*;

module serpent_subkey_store #(
  parameter int NUM_KEYS = SERPENT_NUM_SUBKEYS,
  parameter int KEY_W    = SERPENT_KEY_W,
  parameter int ADDR_W   = SERPENT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [KEY_W-1:0]  i_wr_data,
  input  logic              i_load_done,
  output logic              o_keys_ready,
  input  logic              i_start,
`ifdef SUBKEY_STORE_REVERSE_EN
  input  logic              i_decrypt,
`endif
  output logic [KEY_W-1:0]  o_rk_data,
  output logic [ADDR_W-1:0] o_rk_idx,
  output logic              o_rk_valid,
  input  logic              i_rk_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_KEYS - 1);

  ss_state_t            state_q;
  logic [ADDR_W-1:0]    idx_q;
  logic [NUM_KEYS-1:0]  bitmap_q;
  logic [NUM_KEYS-1:0]  bitmap_d;
  logic                 done_seen_q;
  logic                 done_seen_d;
  logic                 valid_q;
  logic                 done_q;
  logic                 err_q;
  logic                 ready_q;
  logic                 rev_q;
  logic [ADDR_W-1:0]    start_idx;
  logic [ADDR_W-1:0]    end_idx;
  logic [ADDR_W-1:0]    step_idx;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_en;
  logic                 streaming;
  logic                 addr_ok;
  logic                 wr_ok;
  logic                 start_ok;
  logic                 xfer;
  logic                 last_beat;
  logic                 illegal;

`ifdef SUBKEY_STORE_REVERSE_EN
  assign start_idx = i_decrypt ? LAST : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)       rev_q <= 1'b0;
    else if (start_ok) rev_q <= i_decrypt;
  end
`else
  assign start_idx = '0;
  assign rev_q     = 1'b0;
`endif

  assign streaming = (state_q == STREAM);
  assign addr_ok   = (i_wr_addr <= LAST);
  assign wr_ok     = i_wr_en & addr_ok
                   & ~streaming & ~i_clear;
  assign start_ok  = i_start & ready_q
                   & ~streaming & ~i_clear;
  assign xfer      = valid_q & i_rk_ready;
  assign end_idx   = rev_q ? '0 : LAST;
  assign last_beat = xfer & (idx_q == end_idx);
  assign step_idx  = rev_q ? idx_q - ADDR_W'(1)
                           : idx_q + ADDR_W'(1);
  assign illegal   = (i_wr_en & (~addr_ok | streaming))
                   | (i_start & (~ready_q | streaming));

  // Read-ahead: fetch the next slot in the same cycle a beat
  // is accepted so the following cycle already presents it.
  assign rd_en   = start_ok
                 | (streaming & xfer & ~last_beat & ~i_clear);
  assign rd_addr = start_ok ? start_idx : step_idx;

  always_comb begin
    bitmap_d    = bitmap_q;
    done_seen_d = done_seen_q | i_load_done;
    if (wr_ok) bitmap_d[i_wr_addr] = 1'b1;
    if (i_clear) begin
      bitmap_d    = '0;
      done_seen_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bitmap_q    <= '0;
      done_seen_q <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bitmap_q    <= bitmap_d;
      done_seen_q <= done_seen_d;
      ready_q     <= (&bitmap_d) & done_seen_d;
      err_q       <= ~i_clear & illegal;
      done_q      <= 1'b0;
      if (i_clear) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else if (start_ok) begin
        state_q <= STREAM;
        valid_q <= 1'b1;
        idx_q   <= start_idx;
      end else if (streaming && xfer) begin
        if (last_beat) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q <= step_idx;
        end
      end
    end
  end

  subkey_ram #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (wr_ok),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (o_rk_data)
  );

  assign o_keys_ready = ready_q;
  assign o_rk_idx     = idx_q;
  assign o_rk_valid   = valid_q;
  assign o_busy       = streaming;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule
